// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - single-hit TDC measurement sequencer
// Arms the filters, counts coarse cycles between start and stop, captures fine bins and buffers the interval.
module tdc_meas_ctrl #(
  parameter int BIN_W        = 5,
  parameter int CNT_W        = 4,
  parameter int TAPS_PER_CLK = 32,
  parameter int PIPE_LAT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     start_valid,
  input  logic                     stop_valid,
  input  logic [BIN_W-1:0]         bin_start,
  input  logic [BIN_W-1:0]         bin_stop,
  output logic                     filt_enable,
  output logic                     busy,
  output logic [CNT_W+BIN_W-1:0]   result,
  output logic                     ovf,
  output logic                     bin_err,
  output logic                     result_valid,
  input  logic                     result_ready
);

  localparam int RES_W  = CNT_W + BIN_W;
  localparam int CALC_W = RES_W + 1;
  localparam logic [BIN_W:0] TAPS_LIM = (BIN_W+1)'(TAPS_PER_CLK);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RUN, S_WAIT_FINE, S_CALC, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    coarse;
  logic [PIPE_LAT-1:0] start_sr, stop_sr;
  logic                start_flag, stop_flag, ovf_pend;
  logic [BIN_W-1:0]    start_bin, stop_bin;
  logic                launch_start, launch_stop, timeout;
  logic [CALC_W-1:0]   diff;
  logic                diff_neg, bins_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    launch_start = 1'b0;
    launch_stop  = 1'b0;
    timeout      = 1'b0;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: if (start_valid) begin
        launch_start = 1'b1;
        state_nxt    = S_RUN;
      end
      S_RUN: begin
        if (stop_valid) begin
          launch_stop = 1'b1;
          state_nxt   = S_WAIT_FINE;
        end else if (&coarse) begin
          // a timeout never gets a stop bin, so only the start bin is awaited
          timeout   = 1'b1;
          state_nxt = start_flag ? S_CALC : S_WAIT_FINE;
        end
      end
      S_WAIT_FINE: if (start_flag && (ovf_pend || stop_flag)) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_OUT;
      S_OUT:   if (result_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt    = S_IDLE;
      launch_start = 1'b0;
      launch_stop  = 1'b0;
      timeout      = 1'b0;
    end
  end

  // Sign bit of the extra MSB marks a negative interval (stop bin beyond start bin + coarse).
  assign diff     = CALC_W'(coarse) * CALC_W'(TAPS_PER_CLK) + CALC_W'(start_bin) - CALC_W'(stop_bin);
  assign diff_neg = diff[CALC_W-1];
  assign bins_bad = (start_flag && ({1'b0, start_bin} >= TAPS_LIM)) ||
                    (stop_flag  && ({1'b0, stop_bin}  >= TAPS_LIM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coarse     <= '0;
      start_sr   <= '0;
      stop_sr    <= '0;
      start_flag <= 1'b0;
      stop_flag  <= 1'b0;
      ovf_pend   <= 1'b0;
      start_bin  <= '0;
      stop_bin   <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      bin_err    <= 1'b0;
    end else if (abort) begin
      coarse     <= '0;
      start_sr   <= '0;
      stop_sr    <= '0;
      start_flag <= 1'b0;
      stop_flag  <= 1'b0;
      ovf_pend   <= 1'b0;
      start_bin  <= '0;
      stop_bin   <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      bin_err    <= 1'b0;
    end else begin
      start_sr <= (start_sr << 1) | PIPE_LAT'(launch_start);
      stop_sr  <= (stop_sr << 1)  | PIPE_LAT'(launch_stop);
      if (start_sr[PIPE_LAT-1]) begin
        start_bin  <= bin_start;
        start_flag <= 1'b1;
      end
      if (stop_sr[PIPE_LAT-1]) begin
        stop_bin  <= bin_stop;
        stop_flag <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          start_flag <= 1'b0;
          stop_flag  <= 1'b0;
          ovf_pend   <= 1'b0;
        end
        S_ARMED: if (launch_start) coarse <= CNT_W'(1);
        S_RUN: begin
          if (timeout)           ovf_pend <= 1'b1;
          else if (!launch_stop) coarse   <= coarse + CNT_W'(1);
        end
        S_CALC: begin
          if (ovf_pend) begin
            result  <= '1;
            ovf     <= 1'b1;
            bin_err <= bins_bad;
          end else begin
            result  <= diff_neg ? '0 : diff[RES_W-1:0];
            ovf     <= 1'b0;
            bin_err <= diff_neg | bins_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign filt_enable  = (state == S_ARMED) || (state == S_RUN);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_OUT);

endmodule
